// File: rtl/lpc_record_scheduler_if.sv
// Record-in / byte-out bus of the LPC record scheduler.
// Handshake: a record on in_* is a one-cycle strobe qualified by in_valid (and
// enable); there is no input back-pressure. A stream byte is transferred at a
// rising edge where out_valid && out_ready; while out_valid && !out_ready the
// producer holds out_byte stable.
interface lpc_record_scheduler_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          enable;
   logic          in_valid;
   logic [3:0]    in_cyctype_dir;
   logic [31:0]   in_addr;
   logic [31:0]   in_data;
   logic [3:0]    in_data_size;
   logic [7:0]    out_byte;
   logic          out_valid;
   logic          out_ready;
   logic          out_busy;
   logic [LW-1:0] out_level;
   logic [7:0]    out_dropped;
   logic          out_overflow;

   modport master (
      output enable, in_valid, in_cyctype_dir, in_addr, in_data, in_data_size, out_ready,
      input  out_byte, out_valid, out_busy, out_level, out_dropped, out_overflow
   );

   modport slave (
      input  enable, in_valid, in_cyctype_dir, in_addr, in_data, in_data_size, out_ready,
      output out_byte, out_valid, out_busy, out_level, out_dropped, out_overflow
   );
endinterface

// File: rtl/lpc_record_scheduler.sv
// Buffers decoded LPC records in a small FIFO and serialises each one as a
// framed packet: SYNC, header {cyctype_dir, size}, 4 address bytes (MSB first),
// then N data bytes (MSB first). Drops and counts records when the FIFO is full.
module lpc_record_scheduler #(
   parameter int          DEPTH     = 4,
   parameter logic [7:0]  SYNC_BYTE = 8'h5A
) (
   input  logic                  lpc_clock,
   input  logic                  lpc_reset,
   lpc_record_scheduler_if.slave bus,
   output logic [2:0]            dbg_state
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SYNC = 3'd1,
      S_HDR  = 3'd2,
      S_ADDR = 3'd3,
      S_DATA = 3'd4
   } state_t;

   // record storage
   logic [3:0]  mem_ctd  [DEPTH];
   logic [31:0] mem_addr [DEPTH];
   logic [31:0] mem_data [DEPTH];
   logic [3:0]  mem_size [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count;
   logic [7:0]    dropped;
   logic          overflow;

   // record being serialised
   logic [3:0]  sh_ctd;
   logic [31:0] sh_addr;
   logic [31:0] sh_data;
   logic [3:0]  sh_size;

   state_t      state, state_next;
   logic [1:0]  cnt, cnt_next;
   logic        pop;
   logic        out_valid_c;
   logic [7:0]  out_byte_c;

   logic        push_req, push_ok, drop;
   logic [3:0]  size_norm;

   // A full FIFO still accepts a record when the serialiser frees a slot the same cycle.
   assign push_req = bus.in_valid && bus.enable;
   assign push_ok  = push_req && ((count != LW'(DEPTH)) || pop);
   assign drop     = push_req && !push_ok;

   // Only 0/1/2/4 are legal data sizes; anything else is widened to a full word.
   always_comb begin
      size_norm = 4'd4;
      if (bus.in_data_size == 4'd0 || bus.in_data_size == 4'd1 ||
          bus.in_data_size == 4'd2 || bus.in_data_size == 4'd4)
         size_norm = bus.in_data_size;
   end

   // Record array write port (contents need no reset; pointers gate validity).
   always_ff @(posedge lpc_clock) begin
      if (push_ok) begin
         mem_ctd[wr_ptr]  <= bus.in_cyctype_dir;
         mem_addr[wr_ptr] <= bus.in_addr;
         mem_data[wr_ptr] <= bus.in_data;
         mem_size[wr_ptr] <= size_norm;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating drop counter and sticky overflow flag.
   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) begin
         dropped  <= '0;
         overflow <= 1'b0;
      end else if (drop) begin
         if (dropped != 8'hFF) dropped <= dropped + 8'd1;
         overflow <= 1'b1;
      end
   end

   // Shadow register: the popped head record, held for the whole packet.
   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) begin
         sh_ctd  <= '0;
         sh_addr <= '0;
         sh_data <= '0;
         sh_size <= '0;
      end else if (pop) begin
         sh_ctd  <= mem_ctd[rd_ptr];
         sh_addr <= mem_addr[rd_ptr];
         sh_data <= mem_data[rd_ptr];
         sh_size <= mem_size[rd_ptr];
      end
   end

   // Serialiser state and byte counter registers.
   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Serialiser next state and outputs; bytes come straight from registers so
   // they stay stable while the sink stalls.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      pop         = 1'b0;
      out_valid_c = 1'b0;
      out_byte_c  = 8'h00;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               state_next = S_SYNC;
            end
         end
         S_SYNC: begin
            out_valid_c = 1'b1;
            out_byte_c  = SYNC_BYTE;
            if (bus.out_ready) state_next = S_HDR;
         end
         S_HDR: begin
            out_valid_c = 1'b1;
            out_byte_c  = {sh_ctd, sh_size};
            if (bus.out_ready) begin
               cnt_next   = 2'd3;
               state_next = S_ADDR;
            end
         end
         S_ADDR: begin
            out_valid_c = 1'b1;
            out_byte_c  = sh_addr[{cnt, 3'b000} +: 8];
            if (bus.out_ready) begin
               if (cnt == 2'd0) begin
                  if (sh_size == 4'd0) begin
                     state_next = S_IDLE;
                  end else begin
                     cnt_next   = sh_size[1:0] - 2'd1;
                     state_next = S_DATA;
                  end
               end else begin
                  cnt_next = cnt - 2'd1;
               end
            end
         end
         S_DATA: begin
            out_valid_c = 1'b1;
            out_byte_c  = sh_data[{cnt, 3'b000} +: 8];
            if (bus.out_ready) begin
               if (cnt == 2'd0) state_next = S_IDLE;
               else             cnt_next   = cnt - 2'd1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign bus.out_byte     = out_byte_c;
   assign bus.out_valid    = out_valid_c;
   assign bus.out_busy     = (state != S_IDLE);
   assign bus.out_level    = count;
   assign bus.out_dropped  = dropped;
   assign bus.out_overflow = overflow;
   assign dbg_state        = state;
endmodule

// File: tb/tb_lpc_record_scheduler.sv
// Directed bench for lpc_record_scheduler: packet framing, size handling,
// back-pressure, overflow, full-plus-pop, enable gating and mid-packet reset.
module tb_lpc_record_scheduler;
   logic       lpc_clock;
   logic       lpc_reset;
   logic [2:0] dbg_state;

   lpc_record_scheduler_if #(.DEPTH(4)) bus ();

   lpc_record_scheduler #(.DEPTH(4), .SYNC_BYTE(8'h5A)) dut (
      .lpc_clock (lpc_clock),
      .lpc_reset (lpc_reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / watchdog
   initial lpc_clock = 1'b0;
   always #5 lpc_clock = ~lpc_clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   logic       prev_stall = 1'b0;
   logic [7:0] prev_byte  = 8'h00;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge lpc_clock);
      #1;
   endtask

   task automatic push(input logic [3:0] ctd, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] sz);
      bus.in_cyctype_dir = ctd;
      bus.in_addr        = a;
      bus.in_data        = d;
      bus.in_data_size   = sz;
      bus.in_valid       = 1'b1;
      step();
      bus.in_valid       = 1'b0;
   endtask

   // reference packet built from the framing rules
   task automatic expect_pkt(input logic [3:0] ctd, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] sz);
      logic [3:0] n;
      n = (sz == 4'd0 || sz == 4'd1 || sz == 4'd2 || sz == 4'd4) ? sz : 4'd4;
      exp_q.push_back(8'h5A);
      exp_q.push_back({ctd, n});
      exp_q.push_back(a[31:24]);
      exp_q.push_back(a[23:16]);
      exp_q.push_back(a[15:8]);
      exp_q.push_back(a[7:0]);
      for (int i = int'(n) - 1; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
   endtask

   task automatic wait_bytes(input int n, input int budget, input bit toggle);
      int b;
      b = budget;
      while (got_q.size() < n && b > 0) begin
         if (toggle) bus.out_ready = 1'($urandom_range(0, 1));
         step();
         b--;
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic compare_stream(input string tag);
      check_eq({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_eq({tag, "_byte"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_valid"},    bus.out_valid,    1'b0);
      check_eq({tag, "_byte"},     bus.out_byte,     8'h00);
      check_eq({tag, "_busy"},     bus.out_busy,     1'b0);
      check_eq({tag, "_level"},    bus.out_level,    3'd0);
      check_eq({tag, "_dropped"},  bus.out_dropped,  8'd0);
      check_eq({tag, "_overflow"}, bus.out_overflow, 1'b0);
      check_eq({tag, "_state"},    dbg_state,        3'd0);
   endtask

   // stream monitor: capture accepted bytes, check byte hold under stall
   always @(negedge lpc_clock) begin
      if (lpc_reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && bus.out_valid) check_eq("stall_hold", bus.out_byte, prev_byte);
         if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_byte);
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_byte  = bus.out_byte;
      end
   end

   initial begin
      int b;
      lpc_reset          = 1'b1;
      bus.enable         = 1'b1;
      bus.in_valid       = 1'b0;
      bus.in_cyctype_dir = '0;
      bus.in_addr        = '0;
      bus.in_data        = '0;
      bus.in_data_size   = '0;
      bus.out_ready      = 1'b1;
      step();
      step();
      check_reset_values("reset");
      lpc_reset = 1'b0;
      step();

      // single 1-byte memory read, latency and framing
      push(4'h4, 32'haffe7fe5, 32'h0000006c, 4'd1);
      check_eq("t1_valid_k", bus.out_valid, 1'b0);
      check_eq("t1_level_k", bus.out_level, 3'd1);
      step();
      check_eq("t1_valid_k1", bus.out_valid, 1'b1);
      check_eq("t1_sync_k1",  bus.out_byte,  8'h5A);
      check_eq("t1_busy_k1",  bus.out_busy,  1'b1);
      check_eq("t1_level_k1", bus.out_level, 3'd0);
      exp_q = '{8'h5A, 8'h41, 8'hAF, 8'hFE, 8'h7F, 8'hE5, 8'h6C};
      wait_bytes(7, 40, 1'b0);
      check_eq("t1_busy_end",  bus.out_busy,  1'b0);
      check_eq("t1_valid_end", bus.out_valid, 1'b0);
      compare_stream("t1");
      step();

      // size normalisation: 4, 2, 0, 3, 7
      push(4'h2, 32'h10000000, 32'h12345678, 4'd4);
      push(4'h2, 32'h10000001, 32'h12345678, 4'd2);
      push(4'h2, 32'h10000002, 32'h12345678, 4'd0);
      push(4'h2, 32'h10000003, 32'h12345678, 4'd3);
      push(4'h2, 32'h10000004, 32'h12345678, 4'd7);
      expect_pkt(4'h2, 32'h10000000, 32'h12345678, 4'd4);
      expect_pkt(4'h2, 32'h10000001, 32'h12345678, 4'd2);
      expect_pkt(4'h2, 32'h10000002, 32'h12345678, 4'd0);
      expect_pkt(4'h2, 32'h10000003, 32'h12345678, 4'd3);
      expect_pkt(4'h2, 32'h10000004, 32'h12345678, 4'd7);
      wait_bytes(exp_q.size(), 200, 1'b0);
      check_eq("size_dropped", bus.out_dropped, 8'd0);
      compare_stream("size");

      // random back-pressure
      push(4'h6, 32'hc0de0001, 32'h89abcdef, 4'd4);
      push(4'h7, 32'hc0de0002, 32'h00000055, 4'd1);
      push(4'h0, 32'hc0de0003, 32'h0000beef, 4'd2);
      expect_pkt(4'h6, 32'hc0de0001, 32'h89abcdef, 4'd4);
      expect_pkt(4'h7, 32'hc0de0002, 32'h00000055, 4'd1);
      expect_pkt(4'h0, 32'hc0de0003, 32'h0000beef, 4'd2);
      wait_bytes(exp_q.size(), 400, 1'b1);
      compare_stream("bp");
      step();

      // overflow: 7 pushes with the sink stalled
      bus.out_ready = 1'b0;
      for (int i = 0; i < 7; i++)
         push(4'h1, 32'h20000000 + 32'(i), 32'ha0b0c0d0 + 32'(i), 4'd1);
      for (int i = 0; i < 5; i++)
         expect_pkt(4'h1, 32'h20000000 + 32'(i), 32'ha0b0c0d0 + 32'(i), 4'd1);
      check_eq("ovf_level",    bus.out_level,    3'd4);
      check_eq("ovf_dropped",  bus.out_dropped,  8'd2);
      check_eq("ovf_flag",     bus.out_overflow, 1'b1);
      check_eq("ovf_valid",    bus.out_valid,    1'b1);
      check_eq("ovf_sync",     bus.out_byte,     8'h5A);

      // enable low: record ignored, not counted
      bus.enable = 1'b0;
      push(4'hf, 32'hffffffff, 32'hffffffff, 4'd4);
      bus.enable = 1'b1;
      check_eq("en0_dropped", bus.out_dropped, 8'd2);
      check_eq("en0_level",   bus.out_level,   3'd4);

      // full FIFO plus same-cycle pop: push accepted
      bus.out_ready = 1'b1;
      b = 50;
      while (dbg_state != 3'd0 && b > 0) begin
         step();
         b--;
      end
      check_eq("fp_idle",      dbg_state,     3'd0);
      check_eq("fp_level_pre", bus.out_level, 3'd4);
      push(4'h9, 32'h30000000, 32'h00001122, 4'd2);
      expect_pkt(4'h9, 32'h30000000, 32'h00001122, 4'd2);
      check_eq("fp_dropped", bus.out_dropped, 8'd2);
      check_eq("fp_level",   bus.out_level,   3'd4);
      wait_bytes(exp_q.size(), 400, 1'b0);
      compare_stream("ovf");
      step();

      // reset in the middle of a packet
      push(4'h8, 32'h12345678, 32'hdeadbeef, 4'd4);
      b = 20;
      while (got_q.size() < 3 && b > 0) begin
         step();
         b--;
      end
      check_eq("mid_bytes", 64'(got_q.size()), 64'd3);
      lpc_reset = 1'b1;
      step();
      lpc_reset = 1'b0;
      check_reset_values("midrst");
      got_q.delete();
      step();
      step();
      step();
      check_eq("midrst_quiet", 64'(got_q.size()), 64'd0);
      push(4'h3, 32'h01020304, 32'h000000ab, 4'd1);
      expect_pkt(4'h3, 32'h01020304, 32'h000000ab, 4'd1);
      wait_bytes(exp_q.size(), 40, 1'b0);
      compare_stream("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
